wb_tile_target_mux: RTL



---
 rtl/wb_tile_pkg.sv | 22 ++
 rtl/wb_tile_addr_decode.sv | 35 +++
 rtl/wb_tile_target_mux.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_tile_pkg.sv
// Shared types and helpers for the tile-level Wishbone target multiplexer.
package wb_tile_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [1:0] BteLinear  = 2'b00;

    localparam int unsigned MaxAddrWidth = 64;

    // Callers zero-extend narrower addresses to MaxAddrWidth.
    function automatic logic addr_match(input logic [MaxAddrWidth-1:0] adr,
                                        input logic [MaxAddrWidth-1:0] base,
                                        input logic [MaxAddrWidth-1:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/wb_tile_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching target index wins.
module wb_tile_addr_decode
    import wb_tile_pkg::*;
#(
    parameter int unsigned                        NR_TARGETS  = 2,
    parameter int unsigned                        ADDR_WIDTH  = 32,
    parameter logic [NR_TARGETS*ADDR_WIDTH-1:0]   TARGET_BASE = '0,
    parameter logic [NR_TARGETS*ADDR_WIDTH-1:0]   TARGET_MASK = '0,
    localparam int unsigned                       IdxWidth    = (NR_TARGETS > 1) ?
                                                                $clog2(NR_TARGETS) : 1
) (
    input  logic [ADDR_WIDTH-1:0] adr_i,
    output logic [NR_TARGETS-1:0] match_o,
    output logic [IdxWidth-1:0]   idx_o,
    output logic                  hit_o
);

    always_comb begin
        match_o = '0;
        idx_o   = '0;
        hit_o   = 1'b0;
        // Walk downwards so a lower-indexed match overrides a higher one.
        for (int t = NR_TARGETS - 1; t >= 0; t--) begin
            if (addr_match(MaxAddrWidth'(adr_i),
                           MaxAddrWidth'(TARGET_BASE[t*ADDR_WIDTH +: ADDR_WIDTH]),
                           MaxAddrWidth'(TARGET_MASK[t*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                match_o    = '0;
                match_o[t] = 1'b1;
                idx_o      = IdxWidth'(t);
                hit_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_tile_target_mux.sv
// Routes the NA Wishbone master to one of NR_TARGETS classic slaves, with decode-error,
// watchdog timeout, master-abort handling and a saturating error counter.
module wb_tile_target_mux
    import wb_tile_pkg::*;
#(
    parameter int unsigned                        NR_TARGETS     = 2,
    parameter int unsigned                        DATA_WIDTH     = 32,
    parameter int unsigned                        ADDR_WIDTH     = 32,
    parameter logic [NR_TARGETS*ADDR_WIDTH-1:0]   TARGET_BASE    = '0,
    parameter logic [NR_TARGETS*ADDR_WIDTH-1:0]   TARGET_MASK    = '0,
    parameter int unsigned                        TIMEOUT_CYCLES = 255,
    parameter int unsigned                        ERRCNT_WIDTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst_sys_n,
    input  logic [ADDR_WIDTH-1:0]               wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]               wbm_dat_i,
    input  logic [DATA_WIDTH/8-1:0]             wbm_sel_i,
    input  logic                                wbm_we_i,
    input  logic                                wbm_cyc_i,
    input  logic                                wbm_stb_i,
    output logic                                wbm_ack_o,
    output logic                                wbm_err_o,
    output logic [DATA_WIDTH-1:0]               wbm_dat_o,
    output logic [NR_TARGETS*ADDR_WIDTH-1:0]    wbs_adr_o,
    output logic [NR_TARGETS*DATA_WIDTH-1:0]    wbs_dat_o,
    output logic [NR_TARGETS*DATA_WIDTH/8-1:0]  wbs_sel_o,
    output logic [NR_TARGETS-1:0]               wbs_we_o,
    output logic [NR_TARGETS-1:0]               wbs_cyc_o,
    output logic [NR_TARGETS-1:0]               wbs_stb_o,
    output logic [NR_TARGETS*3-1:0]             wbs_cti_o,
    output logic [NR_TARGETS*2-1:0]             wbs_bte_o,
    input  logic [NR_TARGETS-1:0]               wbs_ack_i,
    input  logic [NR_TARGETS-1:0]               wbs_err_i,
    input  logic [NR_TARGETS*DATA_WIDTH-1:0]    wbs_dat_i,
    output logic                                timeout_o,
    output logic [ERRCNT_WIDTH-1:0]             err_count_o
);

    localparam int unsigned SelWidth  = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth  = (NR_TARGETS > 1) ? $clog2(NR_TARGETS) : 1;
    localparam int unsigned WaitWidth = 16;

    state_e                  state_q, state_d;
    logic [IdxWidth-1:0]     idx_q, idx_d;
    logic [NR_TARGETS-1:0]   oh_q, oh_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [SelWidth-1:0]     sel_q, sel_d;
    logic                    we_q, we_d;
    logic [WaitWidth-1:0]    wait_q, wait_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic                    timeout_q, timeout_d;
    logic [ERRCNT_WIDTH-1:0] errcnt_q;
    logic                    err_inc;

    logic [NR_TARGETS-1:0]   dec_match;
    logic [IdxWidth-1:0]     dec_idx;
    logic                    dec_hit;
    logic                    slv_ack, slv_err;
    logic [DATA_WIDTH-1:0]   slv_rdata;

    wb_tile_addr_decode #(
        .NR_TARGETS  (NR_TARGETS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TARGET_BASE (TARGET_BASE),
        .TARGET_MASK (TARGET_MASK)
    ) u_decode (
        .adr_i   (wbm_adr_i),
        .match_o (dec_match),
        .idx_o   (dec_idx),
        .hit_o   (dec_hit)
    );

    always_comb begin
        slv_ack   = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int t = 0; t < NR_TARGETS; t++) begin
            if (idx_q == IdxWidth'(t)) begin
                slv_ack   = wbs_ack_i[t];
                slv_err   = wbs_err_i[t];
                slv_rdata = wbs_dat_i[t*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        oh_d       = oh_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        timeout_d  = 1'b0;
        err_inc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    if (dec_hit) begin
                        idx_d   = dec_idx;
                        oh_d    = dec_match;
                        adr_d   = wbm_adr_i;
                        dat_d   = wbm_dat_i;
                        sel_d   = wbm_sel_i;
                        we_d    = wbm_we_i;
                        wait_d  = '0;
                        state_d = StBusy;
                    end else begin
                        resp_err_d = 1'b1;
                        err_inc    = 1'b1;
                        state_d    = StResp;
                    end
                end
            end
            StBusy: begin
                wait_d = wait_q + WaitWidth'(1);
                // Priority: master abort, slave err, slave ack, then watchdog.
                if (!wbm_cyc_i) begin
                    state_d = StIdle;
                end else if (slv_err) begin
                    resp_err_d = 1'b1;
                    err_inc    = 1'b1;
                    state_d    = StResp;
                end else if (slv_ack) begin
                    resp_err_d = 1'b0;
                    rdata_d    = we_q ? '0 : slv_rdata;
                    state_d    = StResp;
                end else if (wait_q == WaitWidth'(TIMEOUT_CYCLES - 1)) begin
                    resp_err_d = 1'b1;
                    timeout_d  = 1'b1;
                    err_inc    = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_sys_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            oh_q       <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            wait_q     <= '0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            errcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            oh_q       <= oh_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            wait_q     <= wait_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
            timeout_q  <= timeout_d;
            if (err_inc && (errcnt_q != '1)) begin
                errcnt_q <= errcnt_q + ERRCNT_WIDTH'(1);
            end
        end
    end

    // Unselected slaves, and all slaves outside BUSY, see zeros on every signal.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = '0;
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        for (int t = 0; t < NR_TARGETS; t++) begin
            if ((state_q == StBusy) && oh_q[t]) begin
                wbs_adr_o[t*ADDR_WIDTH +: ADDR_WIDTH] = adr_q;
                wbs_dat_o[t*DATA_WIDTH +: DATA_WIDTH] = dat_q;
                wbs_sel_o[t*SelWidth +: SelWidth]     = sel_q;
                wbs_we_o[t]                           = we_q;
                wbs_cyc_o[t]                          = 1'b1;
                wbs_stb_o[t]                          = 1'b1;
            end
        end
    end

    assign wbs_cti_o   = {NR_TARGETS{CtiClassic}};
    assign wbs_bte_o   = {NR_TARGETS{BteLinear}};
    assign wbm_ack_o   = (state_q == StResp) && !resp_err_q;
    assign wbm_err_o   = (state_q == StResp) && resp_err_q;
    assign wbm_dat_o   = wbm_ack_o ? rdata_q : '0;
    assign timeout_o   = timeout_q;
    assign err_count_o = errcnt_q;

endmodule
